pixel_writeback: RTL and testbench
==================================

PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, giving the words per frame.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the pixel word width.
REQ-003 The block SHALL have parameter ADDR_W, default 5, giving the memory address width; DEPTH SHALL equal 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port trigger, input, 1 bit: a one-cycle pulse that starts frame capture.
REQ-007 The block SHALL have port s_valid, input, 1 bit: upstream pixel valid.
REQ-008 The block SHALL have port s_ready, output, 1 bit: the block accepts a pixel.
REQ-009 The block SHALL have port s_data, input, DATA_W bits: upstream blurred pixel.
REQ-010 The block SHALL have port s_last, input, 1 bit: marks the final pixel of the frame.
REQ-011 The block SHALL have port mem_we, output, 1 bit: write strobe to the frame memory.
REQ-012 The block SHALL have port address, output, ADDR_W bits: frame memory word address.
REQ-013 The block SHALL have port din, output, DATA_W bits: frame memory write data.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a frame is being captured.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-016 The block SHALL have port frame_err, output, 1 bit: framing error flag, sticky until the next trigger.

Function
REQ-017 The FSM SHALL have states IDLE, FILL and DONE.
REQ-018 IDLE SHALL go to FILL on trigger=1; this SHALL clear the word counter wcnt to 0 and clear frame_err.
REQ-019 s_ready SHALL equal 1 only in FILL; a handshake SHALL be s_valid & s_ready.
REQ-020 Each handshake SHALL produce mem_we=1 in the following cycle, with address=wcnt at handshake and din=s_data (write latency 1 cycle). Otherwise mem_we SHALL be 0.
REQ-021 Each handshake SHALL increment wcnt by 1; wcnt SHALL NOT wrap inside a frame.
REQ-022 A handshake with wcnt=DEPTH-1 and s_last=1 SHALL go to DONE with frame_err=0.
REQ-023 A handshake with s_last=1 and wcnt<DEPTH-1 SHALL set frame_err=1 and go to DONE (early last; the short frame is still written).
REQ-024 A handshake with wcnt=DEPTH-1 and s_last=0 SHALL set frame_err=1 and go to DONE (missing last).
REQ-025 DONE SHALL last exactly one cycle, assert done=1 in the same cycle as the final mem_we, and then return to IDLE.
REQ-026 busy SHALL equal 1 in FILL and DONE.
REQ-027 trigger SHALL be ignored in FILL and DONE.
REQ-028 s_valid in IDLE SHALL be ignored; no write SHALL occur.
REQ-029 s_valid deasserted mid-frame SHALL stall the block with no write and wcnt held.

Reset
REQ-030 When rst_n=0, all state SHALL clear asynchronously: FSM=IDLE, wcnt=0, s_ready=0, mem_we=0, address=0, din=0, busy=0, done=0, frame_err=0.
REQ-031 A reset mid-frame SHALL abandon the frame, with no further writes and no done pulse.

Configuration
REQ-032 With PIXEL_WRITEBACK_CLAMP_EN defined, din SHALL saturate to 255 when s_data>255 and otherwise equal s_data.
REQ-033 Without PIXEL_WRITEBACK_CLAMP_EN, din SHALL equal s_data unchanged.

Structure
REQ-034 The package pixel_wb_pkg SHALL hold the FSM state enum typedef and constants PIX_MAX=255, DEFAULT_DEPTH=32.
REQ-035 The output register stage (mem_we/address/din, including the clamp) SHALL be a sub-module named pixel_wb_wstage.

Verification
REQ-036 Reset then trigger, 32 back-to-back pixels of value i with s_last on the 32nd -> writes to address 0..31 with din=i; done=1 exactly once, in the cycle of the address-31 write; frame_err=0.
REQ-037 Trigger, s_last on pixel 10 -> 10 writes to address 0..9; frame_err=1; done pulses; the FSM returns to IDLE.
REQ-038 32 pixels with no s_last -> 32 writes; frame_err=1; done pulses once.
REQ-039 s_valid toggles 1,0,0,1 mid-frame -> no write and wcnt held during the low cycles; addresses stay contiguous.
REQ-040 rst_n=0 at pixel 5 -> all outputs 0 immediately; no done pulse; a subsequent trigger restarts at address 0.
REQ-041 With PIXEL_WRITEBACK_CLAMP_EN defined, s_data=300 -> din=255; s_data=200 -> din=200; without the macro, s_data=300 -> din=300.

Source files
------------

// File: rtl/pixel_wb_pkg.sv
// Shared types and constants for the pixel writeback block.
// Clamp option in the write stage: PIXEL_WRITEBACK_CLAMP_EN.
package pixel_wb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } wb_state_e;

   localparam int PIX_MAX       = 255;
   localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/pixel_wb_wstage.sv
// Registered frame-memory write port (strobe, address, data).
// PIXEL_WRITEBACK_CLAMP_EN saturates written pixels to PIX_MAX.
module pixel_wb_wstage
   import pixel_wb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] din
);

   logic [DATA_W-1:0] pix;

   always_comb begin
`ifdef PIXEL_WRITEBACK_CLAMP_EN
      if (wr_data > DATA_W'(PIX_MAX))
         pix = DATA_W'(PIX_MAX);
      else
         pix = wr_data;
`else
      pix = wr_data;
`endif
   end

   // address/din hold their last value between writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we  <= 1'b0;
         address <= '0;
         din     <= '0;
      end else begin
         mem_we <= wr;
         if (wr) begin
            address <= wr_addr;
            din     <= pix;
         end
      end
   end

endmodule

// File: rtl/pixel_writeback.sv
// Captures one frame of pixels from a valid/ready stream into memory.
// Optional clamp (PIXEL_WRITEBACK_CLAMP_EN) lives in pixel_wb_wstage.
module pixel_writeback
   import pixel_wb_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trigger,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   wb_state_e state, state_n;

   // one spare bit so the count reaches DEPTH instead of wrapping
   logic [ADDR_W:0] wcnt;
   logic            hs;
   logic            at_end;
   logic            fin;
   logic            start;

   assign hs     = s_valid & s_ready;
   assign at_end = (wcnt == (ADDR_W+1)'(DEPTH-1));
   assign fin    = hs & (s_last | at_end);
   assign start  = (state == IDLE) & trigger;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (trigger) state_n = FILL;
         FILL:    if (fin) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: ;
         FILL: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wcnt <= '0;
      else if (start)
         wcnt <= '0;
      else if (hs)
         wcnt <= wcnt + 1'b1;
   end

   // error when s_last and the final slot disagree
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         frame_err <= 1'b0;
      else if (start)
         frame_err <= 1'b0;
      else if (hs && (s_last != at_end))
         frame_err <= 1'b1;
   end

   pixel_wb_wstage #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_wstage (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (hs),
      .wr_addr (wcnt[ADDR_W-1:0]),
      .wr_data (s_data),
      .mem_we  (mem_we),
      .address (address),
      .din     (din)
   );

endmodule

// File: tb/tb_pixel_writeback.sv
// Directed bench for pixel_writeback with a per-cycle frame model.
// Honours PIXEL_WRITEBACK_CLAMP_EN for the expected write data.
module tb_pixel_writeback;

   localparam int DEPTH  = 32;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              trigger = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] din;
   logic              busy;
   logic              done;
   logic              frame_err;

   always #5 clk = ~clk;

   pixel_writeback #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .mem_we    (mem_we),
      .address   (address),
      .din       (din),
      .busy      (busy),
      .done      (done),
      .frame_err (frame_err)
   );

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] d);
`ifdef PIXEL_WRITEBACK_CLAMP_EN
      return (d > 32'd255) ? 32'd255 : d;
`else
      return d;
`endif
   endfunction

   // model: 0 = waiting for trigger, 1 = collecting, 2 = completion cycle
   int          m_phase = 0;
   int          m_cnt   = 0;
   logic        m_err   = 1'b0;
   logic        m_we    = 1'b0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_din   = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_cnt   = 0;
         m_err   = 1'b0;
         m_we    = 1'b0;
      end else begin
         m_we = 1'b0;
         case (m_phase)
            0: if (trigger) begin
               m_phase = 1;
               m_cnt   = 0;
               m_err   = 1'b0;
            end
            1: if (s_valid) begin
               m_we   = 1'b1;
               m_addr = m_cnt;
               m_din  = sat(s_data);
               if (s_last != (m_cnt == DEPTH-1)) m_err = 1'b1;
               if (s_last || m_cnt == DEPTH-1) m_phase = 2;
               m_cnt++;
            end
            default: m_phase = 0;
         endcase
      end
   end

   logic [31:0] tb_mem [0:DEPTH-1];
   int          wr_cnt    = 0;
   int          done_cnt  = 0;
   logic [31:0] done_addr = '0;

   always @(negedge clk) begin
      check("s_ready", s_ready, m_phase == 1);
      check("busy", busy, m_phase != 0);
      check("done", done, m_phase == 2);
      check("mem_we", mem_we, m_we);
      check("frame_err", frame_err, m_err);
      if (m_we) begin
         check("address", address, m_addr);
         check("din", din, m_din);
      end
      if (mem_we) begin
         tb_mem[address] = din;
         wr_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_addr = address;
      end
   end

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic start;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
   endtask

   task automatic frame(input int n, input int last_at,
                        input logic [31:0] base, input bit trig_mid);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = base + i;
         s_last  = (i + 1 == last_at);
         trigger = trig_mid && (i == 3);
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      trigger = 1'b0;
      repeat (3) step();
   endtask

   int w0;
   int d0;

   initial begin
      #1 rst_n = 1'b0;
      step();
      step();
      #1;
      check("rst_mem_we", mem_we, 0);
      check("rst_address", address, 0);
      check("rst_din", din, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", s_ready, 0);
      check("rst_err", frame_err, 0);
      rst_n = 1'b1;
      step();

      s_valid = 1'b1;
      s_data  = 32'd7;
      repeat (3) step();
      s_valid = 1'b0;
      check("idle_no_write", wr_cnt, 0);

      w0 = wr_cnt; d0 = done_cnt;
      start();
      frame(32, 32, 0, 1'b0);
      check("a_writes", wr_cnt - w0, 32);
      check("a_done", done_cnt - d0, 1);
      check("a_done_addr", done_addr, 31);
      check("a_mem0", tb_mem[0], 0);
      check("a_mem17", tb_mem[17], 17);
      check("a_mem31", tb_mem[31], 31);
      check("a_err", frame_err, 0);
      check("a_idle", busy, 0);

      w0 = wr_cnt; d0 = done_cnt;
      start();
      frame(10, 10, 100, 1'b0);
      check("b_writes", wr_cnt - w0, 10);
      check("b_done", done_cnt - d0, 1);
      check("b_done_addr", done_addr, 9);
      check("b_mem9", tb_mem[9], 109);
      check("b_err", frame_err, 1);
      check("b_idle", busy, 0);

      w0 = wr_cnt; d0 = done_cnt;
      start();
      frame(32, 0, 200, 1'b1);
      check("c_writes", wr_cnt - w0, 32);
      check("c_done", done_cnt - d0, 1);
      check("c_done_addr", done_addr, 31);
      check("c_err", frame_err, 1);

      w0 = wr_cnt; d0 = done_cnt;
      start();
      check("d_err_cleared", frame_err, 0);
      for (int i = 0; i < 32; i++) begin
         if (i == 5) begin
            s_valid = 1'b0;
            step();
            step();
         end
         s_valid = 1'b1;
         s_data  = 50 + i;
         s_last  = (i == 31);
         step();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) step();
      check("d_writes", wr_cnt - w0, 32);
      check("d_done", done_cnt - d0, 1);
      check("d_done_addr", done_addr, 31);
      check("d_mem4", tb_mem[4], 54);
      check("d_mem5", tb_mem[5], 55);
      check("d_err", frame_err, 0);

      start();
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 600 + i;
         step();
      end
      #1 rst_n = 1'b0;
      #1;
      check("r_mem_we", mem_we, 0);
      check("r_address", address, 0);
      check("r_din", din, 0);
      check("r_busy", busy, 0);
      check("r_done", done, 0);
      check("r_ready", s_ready, 0);
      check("r_err", frame_err, 0);
      d0 = done_cnt;
      step();
      step();
      rst_n = 1'b1;
      step();
      s_valid = 1'b0;
      step();
      check("r_no_done", done_cnt - d0, 0);
      check("r_idle", busy, 0);
      w0 = wr_cnt; d0 = done_cnt;
      start();
      frame(4, 4, 900, 1'b0);
      check("r2_writes", wr_cnt - w0, 4);
      check("r2_mem0", tb_mem[0], 900);
      check("r2_done_addr", done_addr, 3);

      start();
      s_valid = 1'b1;
      s_data  = 32'd300;
      step();
      s_data  = 32'd200;
      s_last  = 1'b1;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) step();
`ifdef PIXEL_WRITEBACK_CLAMP_EN
      check("clamp_300", tb_mem[0], 255);
`else
      check("clamp_300", tb_mem[0], 300);
`endif
      check("clamp_200", tb_mem[1], 200);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
